// File: rtl/saturn_uart_tx.sv
// rtl/saturn_uart_tx.sv - FIFO-buffered 8N1 serial transmitter for the saturn_bus character stream
module saturn_uart_tx #(
    parameter int CLKS_PER_BIT = 217,
    parameter int FIFO_LOG2    = 4
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [7:0] i_char,
    input  logic       i_char_valid,
    output logic       o_ready,
    output logic       o_tx,
    output logic       o_busy,
    output logic       o_overflow
);

    localparam int BAUD_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0]  BAUD_RELOAD = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [FIFO_LOG2:0] FULL_COUNT  = {1'b1, {FIFO_LOG2{1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    logic [7:0]           mem [1 << FIFO_LOG2];
    logic [FIFO_LOG2-1:0] wr_ptr;
    logic [FIFO_LOG2-1:0] rd_ptr;
    logic [FIFO_LOG2:0]   count;
    logic                 fifo_empty;
    logic                 fifo_full;
    logic                 wr_en;
    logic                 pop;

    state_t               state;
    state_t               state_next;
    logic [BAUD_W-1:0]    baud_cnt;
    logic [BAUD_W-1:0]    baud_next;
    logic [2:0]           bit_idx;
    logic [2:0]           bit_next;
    logic [7:0]           shift_reg;
    logic [7:0]           shift_next;
    logic                 baud_done;
    logic                 tx_next;
    logic                 tx_reg;
    logic                 overflow_reg;

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == FULL_COUNT);
    assign wr_en      = i_char_valid && !fifo_full;
    assign baud_done  = (baud_cnt == '0);

    // Character storage; contents need no reset since count gates every read.
    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= i_char;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + FIFO_LOG2'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + FIFO_LOG2'(1);
            end
            case ({wr_en, pop})
                2'b10:   count <= count + (FIFO_LOG2+1)'(1);
                2'b01:   count <= count - (FIFO_LOG2+1)'(1);
                default: count <= count;
            endcase
            // Full is judged on the registered count, so a same-edge pop cannot rescue the write.
            if (i_char_valid && fifo_full) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (!fifo_empty) begin
                    state_next = S_START;
                end
            end
            S_START: begin
                if (baud_done) begin
                    state_next = S_DATA;
                end
            end
            S_DATA: begin
                if (baud_done && (bit_idx == 3'd7)) begin
                    state_next = S_STOP;
                end
            end
            S_STOP: begin
                if (baud_done) begin
                    state_next = fifo_empty ? S_IDLE : S_START;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        pop        = 1'b0;
        baud_next  = baud_cnt;
        bit_next   = bit_idx;
        shift_next = shift_reg;
        case (state)
            S_IDLE:  pop = !fifo_empty;
            S_STOP:  pop = baud_done && !fifo_empty;
            default: pop = 1'b0;
        endcase

        if (pop) begin
            shift_next = mem[rd_ptr];
            baud_next  = BAUD_RELOAD;
        end else if (state != S_IDLE) begin
            if (baud_done) begin
                baud_next = BAUD_RELOAD;
                if (state == S_START) begin
                    bit_next = 3'd0;
                end else if (state == S_DATA) begin
                    shift_next = {1'b0, shift_reg[7:1]};
                    bit_next   = bit_idx + 3'd1;
                end
            end else begin
                baud_next = baud_cnt - BAUD_W'(1);
            end
        end

        // Line level is computed from the next state so the registered output needs no decode.
        case (state_next)
            S_START: tx_next = 1'b0;
            S_DATA:  tx_next = shift_next[0];
            default: tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            baud_cnt  <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            tx_reg    <= 1'b1;
        end else begin
            baud_cnt  <= baud_next;
            bit_idx   <= bit_next;
            shift_reg <= shift_next;
            tx_reg    <= tx_next;
        end
    end

    assign o_tx       = tx_reg;
    assign o_ready    = !fifo_full;
    assign o_busy     = (state != S_IDLE) || !fifo_empty;
    assign o_overflow = overflow_reg;

endmodule

// File: doc/saturn_uart_tx.md
# saturn_uart_tx

Serial transmitter for the character stream the `saturn_bus` debug port emits on `o_char_to_send`. It sits in `saturn_top` beside the bus, buffers characters in a small FIFO and shifts them out as 8N1 asynchronous serial frames on the board's FTDI RX line, so console output reaches a host terminal as well as the LEDs. It is the receiving end of the bus's character output and the sending end of the serial link.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 217: clock cycles per serial bit (25 MHz / 115200). Must be >= 2.
- `FIFO_LOG2`, default 4: FIFO depth is 2^FIFO_LOG2 entries, 8 bits each.

Ports (one clock; reset is synchronous and active-high):
- `i_clk`  in  1  system clock, `clk_25mhz` on the board. All logic uses the rising edge.
- `i_reset`  in  1  synchronous, active-high reset.
- `i_char`  in  8  character to transmit.
- `i_char_valid`  in  1  one-cycle write strobe for `i_char`.
- `o_ready`  out  1  high when the FIFO is not full.
- `o_tx`  out  1  serial line. Idles high.
- `o_busy`  out  1  high when the FIFO is not empty or a frame is in progress.
- `o_overflow`  out  1  sticky flag: a character was dropped.

## Operation
- FIFO:
  - A write occurs on an edge where `i_char_valid` is high and the FIFO is not full.
  - A strobe while full is dropped and sets `o_overflow`. This applies even if a pop happens on the same edge.
  - `o_overflow` stays set until reset.
  - A write and a pop on the same edge leave the count unchanged.
  - Pointers are FIFO_LOG2 bits and wrap modulo the depth. The count is FIFO_LOG2+1 bits.
- `o_ready` = !full. It is derived from the registered count, so it changes one edge after the write or pop that causes it.
- FSM states:
  - IDLE: `o_tx`=1. If the FIFO is not empty, pop the head into the shift register, load the baud counter with CLKS_PER_BIT-1, and go to START.
  - START: `o_tx`=0. When the baud counter reaches 0, reload it, clear the bit index and go to DATA.
  - DATA: `o_tx` = shift[0], sent LSB first. On each counter expiry, shift right and increment the bit index. After bit index 7 expires, go to STOP.
  - STOP: `o_tx`=1. On counter expiry, if the FIFO is not empty, pop and go straight to START with no idle gap; otherwise go to IDLE.
- `o_tx` is registered and glitch-free. Each bit lasts exactly CLKS_PER_BIT cycles, so a frame is 10*CLKS_PER_BIT cycles.
- `o_busy` = (state != IDLE) || (count != 0).

## Timing
- Reset values: `o_tx`=1, `o_ready`=1, `o_busy`=0, `o_overflow`=0, FSM in IDLE, FIFO empty, counters 0.
- Latency into an empty, idle block:
  - Strobe sampled on edge k; count=1 after k.
  - Edge k+1: pop, and `o_tx` falls after k+1.
  - Start bit occupies cycles k+1 through k+CLKS_PER_BIT.
  - Stop bit ends 10*CLKS_PER_BIT cycles after edge k+1.
- Back-to-back frames: the next start bit follows the stop bit's last cycle directly.
- Reset mid-frame: on the reset edge, `o_tx` returns to 1, the FIFO is flushed, the FSM returns to IDLE and `o_overflow` clears. A partial frame is abandoned and no stop bit is emitted.
- Reset has priority over a simultaneous `i_char_valid`; that character is discarded.
- The bus clock-enable does not gate this block. It runs on every `i_clk` edge.

## Test plan
Use CLKS_PER_BIT=4 and FIFO_LOG2=4 throughout.
- Reset: hold `i_reset` for 3 cycles, then release. Required: `o_tx`=1, `o_ready`=1, `o_busy`=0, `o_overflow`=0; `o_tx` stays 1 for 100 idle cycles.
- Single character: strobe 0x41 once. Required:
  - `o_tx` falls one edge after the strobe.
  - Line sequence 0,1,0,0,0,0,0,1,0,1, with each level held exactly 4 cycles.
  - `o_busy` falls 40 cycles after `o_tx` first falls.
- Burst/full: strobe 18 characters on consecutive cycles (0x00..0x11). Required:
  - The first 17 are accepted, because one is popped on the second edge.
  - `o_ready` is low after the 17th write and the 18th is dropped, so `o_overflow`=1.
  - 17 contiguous frames carry 0x00..0x10 in order with no idle cycles between them.
- Simultaneous write and pop: with the FIFO at 16 entries, strobe on the STOP-expiry edge. Required: the character is dropped and `o_overflow` is set. With the FIFO at 15 entries, the same stimulus is accepted and the count stays at 15.
- Reset mid-frame: strobe 0xFF, then assert `i_reset` during data bit 3. Required:
  - `o_tx`=1 the cycle after reset.
  - `o_busy`=0 and the FIFO is empty.
  - A subsequent strobe of 0x55 produces a clean frame 0,1,0,1,0,1,0,1,0,1.
- Wrap-around: send 40 characters in bursts of 10, waiting for `o_busy` to fall between bursts. Required: all 40 are received in order with correct values and `o_overflow` stays 0.
